mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer for the basic processor. It shares one synchronous-read data memory between the CPU datapath (LOAD/STORE/LOADR accesses issued in the decoder's execute phase) and a host/debug loader port. Each access is latched and sequenced through a fixed-latency memory cycle, then acknowledged. It also produces a stall indication that the controller uses to hold the execute phase until the memory operation completes.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing one sync-read data memory between CPU and host.
// Latency : MEM_LAT+1 cycles from request (sampled in IDLE) to the one-cycle ack; MEM_LAT+2 per access.
// Backpr. : requesters hold req until ack; cpu_stall = cpu_req & ~cpu_ack holds the execute phase.
//
// Ports:
//   clock, n_reset                        clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata -> ack/rdata    CPU access channel, cpu_stall for the controller
//   host_req/we/addr/wdata -> ack/rdata   host/debug loader access channel
//   mem_addr/wdata/we, mem_rdata          single-port memory interface
//   busy                                  high whenever the sequencer is not IDLE
module mem_arbiter #(
    parameter int A_W     = 5,
    parameter int D_W     = 8,
    parameter int MEM_LAT = 2
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic           cpu_req,
    input  logic           cpu_we,
    input  logic [A_W-1:0] cpu_addr,
    input  logic [D_W-1:0] cpu_wdata,
    output logic           cpu_ack,
    output logic [D_W-1:0] cpu_rdata,
    output logic           cpu_stall,
    input  logic           host_req,
    input  logic           host_we,
    input  logic [A_W-1:0] host_addr,
    input  logic [D_W-1:0] host_wdata,
    output logic           host_ack,
    output logic [D_W-1:0] host_rdata,
    output logic [A_W-1:0] mem_addr,
    output logic [D_W-1:0] mem_wdata,
    output logic           mem_we,
    input  logic [D_W-1:0] mem_rdata,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_HOST = 1'b1;
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic       lat_we;
    logic [2:0] lat_cnt;

    // CPU wins when alone, or on a tie when the host was served last.
    logic cpu_win;
    assign cpu_win = cpu_req & (~host_req | (last_owner == OWN_HOST));

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            owner      <= OWN_HOST;
            last_owner <= OWN_HOST;
            lat_we     <= 1'b0;
            lat_cnt    <= 3'd0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || host_req) begin
                        owner      <= cpu_win ? OWN_CPU : OWN_HOST;
                        last_owner <= cpu_win ? OWN_CPU : OWN_HOST;
                        lat_we     <= cpu_win ? cpu_we : host_we;
                        // mem_we is raised here so it is high only in the first ACCESS cycle.
                        mem_we     <= cpu_win ? cpu_we : host_we;
                        mem_addr   <= cpu_win ? cpu_addr : host_addr;
                        mem_wdata  <= cpu_win ? cpu_wdata : host_wdata;
                        lat_cnt    <= LAT_INIT;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (lat_cnt == 3'd0) begin
                        if (!lat_we) begin
                            if (owner == OWN_CPU) begin
                                cpu_rdata <= mem_rdata;
                            end else begin
                                host_rdata <= mem_rdata;
                            end
                        end
                        if (owner == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                        end else begin
                            host_ack <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    cpu_ack  <= 1'b0;
                    host_ack <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1 instances).
// Latency : inputs driven and outputs sampled on the falling edge; "cycle T" is the cycle a req is driven in.
// Backpr. : requests are held until the ack cycle, then dropped unless a follow-on access is intended.
module tb_mem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic n_reset;

    // MEM_LAT = 2 instance with a synchronous-read memory model
    logic       cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       host_req, host_we, host_ack;
    logic [4:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_we, busy;

    // MEM_LAT = 1 instance with a combinational-read memory model
    logic       b_cpu_req, b_cpu_we, b_cpu_ack, b_cpu_stall;
    logic [4:0] b_cpu_addr;
    logic [7:0] b_cpu_wdata, b_cpu_rdata;
    logic       b_host_req, b_host_we, b_host_ack;
    logic [4:0] b_host_addr;
    logic [7:0] b_host_wdata, b_host_rdata;
    logic [4:0] b_mem_addr;
    logic [7:0] b_mem_wdata, b_mem_rdata;
    logic       b_mem_we, b_busy;

    logic       pre_we;
    logic [4:0] pre_addr;
    logic [7:0] pre_data;
    logic [7:0] mem [32];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.A_W(5), .D_W(8), .MEM_LAT(2)) dut (
        .clock(clock), .n_reset(n_reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_arbiter #(.A_W(5), .D_W(8), .MEM_LAT(1)) dut_b (
        .clock(clock), .n_reset(n_reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(b_host_wdata),
        .host_ack(b_host_ack), .host_rdata(b_host_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    assign b_mem_rdata = (b_mem_addr == 5'd4) ? 8'h4B : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    // Called at a falling edge with the DUT idle; issues a CPU read and checks ack/data timing.
    task automatic cpu_rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            chk({tag, "_ack"}, 32'(cpu_ack), 32'(n == 3));
            chk({tag, "_we"}, 32'(mem_we), 32'd0);
            if (n == 3) begin
                chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp));
                cpu_req = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_host_req = 1'b0; b_host_we = 1'b0; b_host_addr = '0; b_host_wdata = '0;

        preload(5'd1, 8'hC1);
        preload(5'd2, 8'hD2);
        preload(5'd3, 8'h33);
        preload(5'd5, 8'h3C);
        preload(5'd7, 8'h11);
        preload(5'd9, 8'h99);
        preload(5'd12, 8'h77);

        // Reset state
        @(negedge clock);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);

        // Tie in the first IDLE after reset: CPU, HOST, CPU, HOST, acks 4 cycles apart
        n_reset   = 1'b1;
        cpu_req   = 1'b1; cpu_we  = 1'b0; cpu_addr  = 5'd1;
        host_req  = 1'b1; host_we = 1'b0; host_addr = 5'd2;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            chk("tie_cpu_ack", 32'(cpu_ack), 32'(n == 3 || n == 11));
            chk("tie_host_ack", 32'(host_ack), 32'(n == 7 || n == 15));
            chk("tie_both_ack", 32'(cpu_ack & host_ack), 32'd0);
            chk("tie_busy", 32'(busy), 32'((n % 4) != 0));
            chk("tie_stall", 32'(cpu_stall), 32'(!(n == 3 || n == 11)));
            if (n == 3 || n == 11) chk("tie_cpu_rdata", 32'(cpu_rdata), 32'h0C1);
            if (n == 7 || n == 15) chk("tie_host_rdata", 32'(host_rdata), 32'h0D2);
            if (n == 15) begin
                cpu_req  = 1'b0;
                host_req = 1'b0;
            end
        end
        @(negedge clock);
        chk("tie_idle_busy", 32'(busy), 32'd0);

        // Single CPU read of addr 5
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            chk("rd5_mem_we", 32'(mem_we), 32'd0);
            chk("rd5_cpu_ack", 32'(cpu_ack), 32'(n == 3));
            chk("rd5_host_ack", 32'(host_ack), 32'd0);
            chk("rd5_busy", 32'(busy), 32'(n <= 3));
            if (n == 3) begin
                chk("rd5_rdata", 32'(cpu_rdata), 32'h03C);
                cpu_req = 1'b0;
            end
        end

        // Host write of 0xA5 to addr 7
        host_req = 1'b1; host_we = 1'b1; host_addr = 5'd7; host_wdata = 8'hA5;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            chk("wr7_mem_we", 32'(mem_we), 32'(n == 1));
            chk("wr7_host_ack", 32'(host_ack), 32'(n == 3));
            chk("wr7_cpu_ack", 32'(cpu_ack), 32'd0);
            if (n == 1) begin
                chk("wr7_mem_addr", 32'(mem_addr), 32'd7);
                chk("wr7_mem_wdata", 32'(mem_wdata), 32'h0A5);
            end
            if (n == 3) begin
                chk("wr7_host_rdata", 32'(host_rdata), 32'h0D2);
                host_req = 1'b0;
                host_we  = 1'b0;
            end
        end
        cpu_rd("rd7", 5'd7, 8'hA5);

        // Address change after grant is ignored
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
        #1;
        chk("chg_stall_req", 32'(cpu_stall), 32'd1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            chk("chg_stall", 32'(cpu_stall), 32'(n <= 2));
            if (n <= 2) chk("chg_mem_addr", 32'(mem_addr), 32'd3);
            if (n == 1) cpu_addr = 5'd9;
            if (n == 3) begin
                chk("chg_rdata", 32'(cpu_rdata), 32'h033);
                cpu_req = 1'b0;
            end
        end

        // Reset in the first ACCESS cycle of a CPU write to addr 12
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd12; cpu_wdata = 8'hEE;
        @(negedge clock);
        chk("mid_mem_we_pre", 32'(mem_we), 32'd1);
        chk("mid_mem_addr_pre", 32'(mem_addr), 32'd12);
        n_reset = 1'b0;
        #1;
        chk("mid_mem_we", 32'(mem_we), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("mid_host_rdata", 32'(host_rdata), 32'd0);
        chk("mid_cpu_ack", 32'(cpu_ack), 32'd0);
        @(negedge clock);
        n_reset = 1'b1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clock);
            chk("mid_no_ack", 32'(cpu_ack), 32'd0);
            chk("mid_idle", 32'(busy), 32'd0);
        end
        chk("mid_mem12", 32'(mem[12]), 32'h077);
        cpu_rd("rd12", 5'd12, 8'h77);

        // MEM_LAT = 1: host read of addr 4
        b_host_req = 1'b1; b_host_we = 1'b0; b_host_addr = 5'd4;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clock);
            chk("l1_mem_we", 32'(b_mem_we), 32'd0);
            chk("l1_host_ack", 32'(b_host_ack), 32'(n == 2));
            chk("l1_cpu_ack", 32'(b_cpu_ack), 32'd0);
            chk("l1_busy", 32'(b_busy), 32'(n <= 2));
            if (n == 1) chk("l1_mem_addr", 32'(b_mem_addr), 32'd4);
            if (n == 2) begin
                chk("l1_rdata", 32'(b_host_rdata), 32'h04B);
                b_host_req = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
